ps2_host_tx: RTL
================

# ps2_host_tx

PS/2 host-to-device transmitter: sends one command byte (e.g. 8'hED set-LEDs, 8'hFF reset) from the host to a PS/2 keyboard over the shared open-drain clock/data lines. It is the outbound companion of the PS/2 keyboard receiver and sits beside it in the keyboard front end, driving pull-low enables for the top-level tristate pads. It performs the full host request sequence (clock inhibit, start request, device-clocked bit shifting, acknowledge check) and reports completion status.

## Interface
- INHIBIT_CYCLES, 5000: clk cycles ps2_clk is held low before the request (≥100 µs at 50 MHz).
- TIMEOUT_CYCLES, 1000000: max clk cycles from clock release to end of frame (20 ms at 50 MHz); used only with PS2_TX_TIMEOUT_EN.
- clk  in  1  system clock.
- clrn  in  1  reset, asynchronous, active-low.
- ps2_clk  in  1  raw PS/2 clock pin level.
- ps2_data  in  1  raw PS/2 data pin level.
- tx_data  in  8  command byte, captured on handshake.
- tx_valid  in  1  request to send tx_data.
- tx_ready  out  1  high only in IDLE; handshake when tx_valid & tx_ready.
- ps2_clk_oe  out  1  1 = pull ps2_clk low, 0 = release.
- ps2_data_oe  out  1  1 = pull ps2_data low, 0 = release.
- busy  out  1  high from handshake until return to IDLE; the top level uses it to gate the receiver.
- done  out  1  one-cycle pulse at frame end.
- ack_ok  out  1  valid with done: 1 = device acknowledged, 0 = NAK.
- timeout  out  1  one-cycle pulse on watchdog expiry.

## Operation
- Inputs pass through a 3-stage synchronizer. Falling edge = sync[2] & ~sync[1]. ps2_data is sampled from its synchronized copy.
- Frame shift register, 10 bits, LSB first: {stop=1, parity=~^tx_data, tx_data[7:0]}. Parity is odd over the data byte.
- States:
  - IDLE: tx_ready=1, both oe=0. On handshake, load the shift register, clear the bit counter and cycle counter, go to INHIBIT.
  - INHIBIT: clk_oe=1, data_oe=0 for INHIBIT_CYCLES cycles, then go to REQ.
  - REQ: clk_oe=1, data_oe=1 for exactly one cycle (start bit = 0), then go to SEND.
  - SEND: clk_oe=0. On each detected falling edge, data_oe = ~shift[0], shift right, and the bit counter increments. Edges 1–8 drive data bits, edge 9 drives parity, edge 10 drives stop (data_oe=0). After edge 10, go to ACK.
  - ACK: on the next falling edge (edge 11), ack_ok is registered as ~synced ps2_data, then go to WAIT_IDLE.
  - WAIT_IDLE: wait until synced ps2_clk and ps2_data are both 1, pulse done for one cycle, return to IDLE.
- tx_valid while busy is ignored; the byte is not queued.
- ack_ok holds its value until the next done.

## Timing
- Reset values: ps2_clk_oe=0, ps2_data_oe=0, tx_ready=1, busy=0, done=0, ack_ok=0, timeout=0, state=IDLE.
- clrn low mid-frame releases both lines immediately (asynchronous), with no done and no timeout.
- Handshake at cycle N: busy=1 and clk_oe=1 at N+1.
- REQ lasts 1 cycle. clk_oe falls and data_oe stays 1 in the first SEND cycle.
- data_oe changes 1 cycle after edge detection, which is 3–4 clk cycles after the pin falls. This is well within a half PS/2 clock period (≥30 µs).
- done is asserted 1 cycle after both lines are seen idle-high.
- Bit counter is 4 bits and never wraps. Edges seen in IDLE or INHIBIT are ignored.

## Configuration
- PS2_TX_TIMEOUT_EN defined:
  - A cycle counter runs from entry to SEND.
  - If it reaches TIMEOUT_CYCLES before done, timeout pulses for 1 cycle, both oe are released, done is not pulsed, and the block returns to IDLE the next cycle.
- Undefined: no counter, and the block waits indefinitely for device clocks. timeout is tied to 0.

## Structure
- Package ps2_pkg holds:
  - the state enum (IDLE, INHIBIT, REQ, SEND, ACK, WAIT_IDLE);
  - PS2_FRAME_BITS=11;
  - command constants PS2_CMD_SET_LED=8'hED, PS2_CMD_RESET=8'hFF;
  - response constant PS2_RSP_ACK=8'hFA.
- Sub-module ps2_sync holds the 3-stage synchronizer and falling-edge detect. It is shared with the receiver.

## Test plan
- Reset: hold clrn=0 → both oe=0, tx_ready=1, busy=0, done=0, timeout=0.
- Send 8'hED; device model clocks at 12.5 kHz and acks:
  - pin data at successive device rising edges reads 0,1,0,1,1,0,1,1,1,1,1 (start, data LSB first, parity=1, stop);
  - done pulses with ack_ok=1, tx_ready returns to 1.
- Send 8'h00; device leaves data high at bit 11 → parity bit driven 1, done pulses with ack_ok=0.
- PS2_TX_TIMEOUT_EN with TIMEOUT_CYCLES=2000; device never clocks → timeout pulses 2000 cycles after SEND entry, both oe=0, no done.
- Assert clrn=0 after edge 4 of a frame → both oe=0 in the same cycle. Resume with 8'hFF → full frame completes, ack_ok=1.
- Pulse tx_valid with 8'h55 during busy → ignored. The frame on the wire carries only the first byte, and exactly one done pulse is seen.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host transmitter states, frame length,
// command/response byte constants and a small saturating-counter helper.
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        REQ,
        SEND,
        ACK,
        WAIT_IDLE
    } ps2_state_t;

    // start + 8 data + parity + stop
    localparam int PS2_FRAME_BITS = 11;

    localparam logic [7:0] PS2_CMD_SET_LED = 8'hED;
    localparam logic [7:0] PS2_CMD_RESET   = 8'hFF;
    localparam logic [7:0] PS2_RSP_ACK     = 8'hFA;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [3:0] sat_inc4(input logic [3:0] v);
        return (v == 4'hF) ? v : v + 4'd1;
    endfunction

endpackage

// File: rtl/ps2_sync.sv
// Three-stage synchronizer for the raw PS/2 clock and data pins plus
// falling-edge detection on the clock. Shared with the PS/2 receiver.
// Lines idle high, so the stages reset to 1 to avoid a false edge.
module ps2_sync (
    input  logic clk,
    input  logic clrn,
    input  logic ps2_clk,
    input  logic ps2_data,
    output logic clk_level,
    output logic data_level,
    output logic clk_fall
);

    logic [2:0] clk_sync_reg;
    logic [2:0] data_sync_reg;

    // Shift each raw pin through three flops; stage 0 is the newest sample.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            clk_sync_reg  <= 3'b111;
            data_sync_reg <= 3'b111;
        end else begin
            clk_sync_reg  <= {clk_sync_reg[1:0], ps2_clk};
            data_sync_reg <= {data_sync_reg[1:0], ps2_data};
        end
    end

    assign clk_level  = clk_sync_reg[2];
    assign data_level = data_sync_reg[2];
    // Older stage high, newer stage low: the device pulled the clock down.
    assign clk_fall   = clk_sync_reg[2] & ~clk_sync_reg[1];

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter. Sends one command byte to a keyboard:
// inhibits the clock, issues the start request, shifts the frame out on
// device-generated falling edges, samples the acknowledge bit and reports
// done/ack_ok. Outputs are pull-low enables for open-drain pads.
// Optional watchdog: define PS2_TX_TIMEOUT_EN to abort a frame when the
// device does not finish within TIMEOUT_CYCLES of clock release.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       clrn,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       busy,
    output logic       done,
    output logic       ack_ok,
    output logic       timeout
);

    localparam int CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    logic clk_level;
    logic data_level;
    logic clk_fall;

    ps2_state_t       state_reg,   state_next;
    logic [9:0]       shift_reg,   shift_next;
    logic [3:0]       bit_cnt_reg, bit_cnt_next;
    logic [CNT_W-1:0] cnt_reg,     cnt_next;
    logic             data_oe_reg, data_oe_next;
    logic             ack_bit_reg, ack_bit_next;
    logic             ack_ok_reg,  ack_ok_next;
    logic             done_reg,    done_next;
`ifdef PS2_TX_TIMEOUT_EN
    logic             timeout_reg, timeout_next;
`endif

    ps2_sync u_sync (
        .clk        (clk),
        .clrn       (clrn),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .clk_level  (clk_level),
        .data_level (data_level),
        .clk_fall   (clk_fall)
    );

    // State and datapath registers; reset releases both lines at once.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_reg   <= IDLE;
            shift_reg   <= '1;
            bit_cnt_reg <= '0;
            cnt_reg     <= '0;
            data_oe_reg <= 1'b0;
            ack_bit_reg <= 1'b0;
            ack_ok_reg  <= 1'b0;
            done_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            shift_reg   <= shift_next;
            bit_cnt_reg <= bit_cnt_next;
            cnt_reg     <= cnt_next;
            data_oe_reg <= data_oe_next;
            ack_bit_reg <= ack_bit_next;
            ack_ok_reg  <= ack_ok_next;
            done_reg    <= done_next;
        end
    end

`ifdef PS2_TX_TIMEOUT_EN
    // Watchdog pulse register.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            timeout_reg <= 1'b0;
        end else begin
            timeout_reg <= timeout_next;
        end
    end
`endif

    // Next-state and datapath logic for the host request sequence.
    always_comb begin
        state_next   = state_reg;
        shift_next   = shift_reg;
        bit_cnt_next = bit_cnt_reg;
        cnt_next     = cnt_reg;
        data_oe_next = data_oe_reg;
        ack_bit_next = ack_bit_reg;
        ack_ok_next  = ack_ok_reg;
        done_next    = 1'b0;
`ifdef PS2_TX_TIMEOUT_EN
        timeout_next = 1'b0;
`endif

        case (state_reg)
            IDLE: begin
                data_oe_next = 1'b0;
                if (tx_valid) begin
                    // {stop, odd parity, data}; bit 0 goes out first
                    shift_next   = {1'b1, ~^tx_data, tx_data};
                    bit_cnt_next = '0;
                    cnt_next     = '0;
                    state_next   = INHIBIT;
                end
            end
            INHIBIT: begin
                if (cnt_reg == CNT_W'(INHIBIT_CYCLES - 1)) begin
                    data_oe_next = 1'b1;     // start bit, held into SEND
                    state_next   = REQ;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            REQ: begin
                cnt_next   = '0;             // watchdog measures from SEND entry
                state_next = SEND;
            end
            SEND: begin
                if (clk_fall) begin
                    data_oe_next = ~shift_reg[0];
                    shift_next   = {1'b1, shift_reg[9:1]};
                    bit_cnt_next = sat_inc4(bit_cnt_reg);
                    // this edge drives the stop bit
                    if (bit_cnt_reg == 4'(PS2_FRAME_BITS - 2)) begin
                        state_next = ACK;
                    end
                end
            end
            ACK: begin
                if (clk_fall) begin
                    ack_bit_next = ~data_level;
                    bit_cnt_next = sat_inc4(bit_cnt_reg);
                    state_next   = WAIT_IDLE;
                end
            end
            WAIT_IDLE: begin
                if (clk_level && data_level) begin
                    done_next   = 1'b1;
                    ack_ok_next = ack_bit_reg;   // ack_ok only moves with done
                    state_next  = IDLE;
                end
            end
            default: begin
                data_oe_next = 1'b0;
                state_next   = IDLE;
            end
        endcase

`ifdef PS2_TX_TIMEOUT_EN
        // Abort a stalled frame; a frame that completes this cycle wins.
        if (state_reg inside {SEND, ACK, WAIT_IDLE}) begin
            if ((cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1)) && !done_next) begin
                timeout_next = 1'b1;
                data_oe_next = 1'b0;
                state_next   = IDLE;
            end else begin
                cnt_next = cnt_reg + CNT_W'(1);
            end
        end
`endif
    end

    assign tx_ready    = (state_reg == IDLE);
    assign busy        = (state_reg != IDLE);
    assign ps2_clk_oe  = (state_reg == INHIBIT) || (state_reg == REQ);
    assign ps2_data_oe = data_oe_reg;
    assign done        = done_reg;
    assign ack_ok      = ack_ok_reg;
`ifdef PS2_TX_TIMEOUT_EN
    assign timeout     = timeout_reg;
`else
    assign timeout     = 1'b0;
`endif

endmodule
